// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, control encodings and helper types for the
// instruction fetch stage (if_stage) and its IF/ID register (if_stage_if_id).
// Optional feature macro: IF_ADDR_EXCP_EN (instruction address exception).
package if_stage_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    typedef logic [InstAddrBus-1:0] inst_addr_t;
    typedef logic [InstBus-1:0]     inst_t;

    localparam inst_t ZeroWord    = '0;
    localparam logic  RstEnable   = 1'b1;
    localparam logic  ChipEnable  = 1'b1;
    localparam logic  ChipDisable = 1'b0;
    localparam logic  Stop        = 1'b1;
    localparam logic  NoStop      = 1'b0;

    // Stall vector bit positions.
    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_IF = 1;
    localparam int unsigned STALL_ID = 2;

    // Exception-type bit flagged for a misaligned fetch address.
    localparam int unsigned EXC_INST_ADDR_BIT = 13;

    // One-entry pending branch captured while the PC is stalled.
    typedef struct packed {
        logic       valid;
        inst_addr_t target;
    } pend_br_t;

    function automatic logic is_misaligned(input inst_addr_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-side bus of the IF stage.
//   pc, ce          : fetch address / chip enable towards the instruction ROM
//   rom_inst_i      : instruction returned combinationally by the ROM
//   id_pc, id_inst  : IF/ID register contents towards decode
//   id_excepttype   : IF/ID exception word (only with IF_ADDR_EXCP_EN)
// master = if_stage, slave = ROM / decode side.
interface if_stage_if;
    import if_stage_pkg::*;

    inst_addr_t  pc;
    logic        ce;
    inst_t       rom_inst_i;
    inst_addr_t  id_pc;
    inst_t       id_inst;
`ifdef IF_ADDR_EXCP_EN
    logic [31:0] id_excepttype;

    modport master (output pc, ce, id_pc, id_inst, id_excepttype, input rom_inst_i);
    modport slave  (input pc, ce, id_pc, id_inst, id_excepttype, output rom_inst_i);
`else
    modport master (output pc, ce, id_pc, id_inst, input rom_inst_i);
    modport slave  (input pc, ce, id_pc, id_inst, output rom_inst_i);
`endif

endinterface

// File: rtl/if_stage_if_id.sv
// if_stage_if_id: IF/ID pipeline register.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ce                : fetch chip enable (0 -> bubble, ROM is off)
//   flush             : exception flush, forces a bubble
//   stall_if/stall_id : stall bits for IF and ID
//   if_pc, if_inst    : current fetch address and ROM word
//   id_pc, id_inst    : registered outputs to decode
//   id_excepttype     : exception word (only with IF_ADDR_EXCP_EN)
// Optional feature macro: IF_ADDR_EXCP_EN.
module if_stage_if_id
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        flush,
    input  logic        stall_if,
    input  logic        stall_id,
    input  inst_addr_t  if_pc,
    input  inst_t       if_inst,
    output inst_addr_t  id_pc,
    output inst_t       id_inst
`ifdef IF_ADDR_EXCP_EN
    ,
    output logic [31:0] id_excepttype
`endif
);

    inst_addr_t id_pc_q;
    inst_t      id_inst_q;

    // Bubble covers reset, flush, ROM disabled, and IF stalled while ID runs.
    logic bubble;
    logic load;

    always_comb begin
        bubble = (rst == RstEnable) || flush || (ce == ChipDisable) ||
                 ((stall_if == Stop) && (stall_id == NoStop));
        load   = !bubble && (stall_if == NoStop);
    end

`ifdef IF_ADDR_EXCP_EN
    logic [31:0] exc_q;
    logic        bad_addr;

    always_comb bad_addr = is_misaligned(if_pc);

    always_ff @(posedge clk) begin
        if (bubble) begin
            id_pc_q   <= '0;
            id_inst_q <= ZeroWord;
            exc_q     <= '0;
        end else if (load) begin
            id_pc_q   <= if_pc;
            // A misaligned fetch carries no instruction, only the exception.
            id_inst_q <= bad_addr ? ZeroWord : if_inst;
            exc_q     <= '0;
            if (bad_addr) exc_q[EXC_INST_ADDR_BIT] <= 1'b1;
        end
    end

    assign id_excepttype = exc_q;
`else
    always_ff @(posedge clk) begin
        if (bubble) begin
            id_pc_q   <= '0;
            id_inst_q <= ZeroWord;
        end else if (load) begin
            id_pc_q   <= if_pc;
            id_inst_q <= if_inst;
        end
    end
`endif

    assign id_pc   = id_pc_q;
    assign id_inst = id_inst_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage -- PC register, pending-branch buffer and
// the IF/ID register (sub-module if_stage_if_id).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   stall[5:0]                : pipeline stall vector (0=PC, 1=IF, 2=ID)
//   flush, new_pc             : exception redirect and target
//   branch_flag_i,
//   branch_target_address_i   : branch redirect from decode
//   bus (if_stage_if.master)  : pc/ce to ROM, rom_inst_i back, id_pc/id_inst
//                               (and id_excepttype) to decode
// Parameter RESET_PC: first fetch address after reset.
// Optional feature macro: IF_ADDR_EXCP_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       branch_flag_i,
    input  inst_addr_t branch_target_address_i,
    if_stage_if.master bus
);

    inst_addr_t pc_q;
    logic       ce_q;
    pend_br_t   pend_q;

    // A branch arriving while the PC is stalled is parked in pend_q and taken
    // on the first unstalled edge; a live branch on that edge is newer and
    // therefore wins over the parked one.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ce_q   <= ChipDisable;
            pc_q   <= RESET_PC;
            pend_q <= '0;
        end else begin
            ce_q <= ChipEnable;
            if (ce_q == ChipDisable) begin
                pc_q   <= RESET_PC;
                pend_q <= '0;
            end else if (flush) begin
                pc_q   <= new_pc;
                pend_q <= '0;
            end else if (stall[STALL_PC] == Stop) begin
                if (branch_flag_i) begin
                    pend_q <= '{valid: 1'b1, target: branch_target_address_i};
                end
            end else if (branch_flag_i) begin
                pc_q   <= branch_target_address_i;
                pend_q <= '0;
            end else if (pend_q.valid) begin
                pc_q   <= pend_q.target;
                pend_q <= '0;
            end else begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    assign bus.pc = pc_q;
    assign bus.ce = ce_q;

    inst_addr_t id_pc_w;
    inst_t      id_inst_w;
`ifdef IF_ADDR_EXCP_EN
    logic [31:0] id_exc_w;
`endif

    if_stage_if_id u_if_id (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce_q),
        .flush         (flush),
        .stall_if      (stall[STALL_IF]),
        .stall_id      (stall[STALL_ID]),
        .if_pc         (pc_q),
        .if_inst       (bus.rom_inst_i),
        .id_pc         (id_pc_w),
        .id_inst       (id_inst_w)
`ifdef IF_ADDR_EXCP_EN
        ,
        .id_excepttype (id_exc_w)
`endif
    );

    assign bus.id_pc   = id_pc_w;
    assign bus.id_inst = id_inst_w;
`ifdef IF_ADDR_EXCP_EN
    assign bus.id_excepttype = id_exc_w;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage. A driver applies directed and
// random stimulus, steps a behavioural model and queues the expected state
// after each edge; a monitor pops and compares one entry per edge.
// Optional feature macro: IF_ADDR_EXCP_EN.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;

    if_stage_if bus();

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign bus.rom_inst_i = bus.ce ? rom_word(bus.pc) : 32'h0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .bus                     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic [31:0] exc;
    } exp_t;

    exp_t exp_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    logic        m_ce = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt = '0;
    logic [31:0] m_id_pc = '0;
    logic [31:0] m_id_inst = '0;
    logic [31:0] m_exc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_edge();
        logic [31:0] fetched;
        logic [31:0] n_pc;
        logic        n_pend;
        logic [31:0] n_tgt;
        logic        misal;
        exp_t e;
        fetched = m_ce ? rom_word(m_pc) : 32'h0;
        n_pc = m_pc; n_pend = m_pend; n_tgt = m_tgt;
        if (rst) begin
            m_pc = 32'h0; m_ce = 1'b0; m_pend = 1'b0;
            m_id_pc = '0; m_id_inst = '0; m_exc = '0;
        end else begin
            // IF/ID update from the pre-edge fetch state
            misal = 1'b0;
`ifdef IF_ADDR_EXCP_EN
            misal = (m_pc % 4) != 0;
`endif
            if (flush || !m_ce) begin
                m_id_pc = '0; m_id_inst = '0; m_exc = '0;
            end else if (!stall[1]) begin
                m_id_pc = m_pc;
                m_id_inst = misal ? 32'h0 : fetched;
                m_exc = misal ? 32'h0000_2000 : 32'h0;
            end else if (!stall[2]) begin
                m_id_pc = '0; m_id_inst = '0; m_exc = '0;
            end
            // PC and pending branch
            if (!m_ce) begin
                n_pc = 32'h0; n_pend = 1'b0;
            end else if (flush) begin
                n_pc = new_pc; n_pend = 1'b0;
            end else if (stall[0]) begin
                if (branch_flag_i) begin n_pend = 1'b1; n_tgt = branch_target_address_i; end
            end else begin
                if (branch_flag_i)   n_pc = branch_target_address_i;
                else if (m_pend)     n_pc = m_tgt;
                else                 n_pc = m_pc + 32'd4;
                n_pend = 1'b0;
            end
            m_pc = n_pc; m_pend = n_pend; m_tgt = n_tgt; m_ce = 1'b1;
        end
        e.pc = m_pc; e.ce = m_ce; e.id_pc = m_id_pc; e.id_inst = m_id_inst; e.exc = m_exc;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [5:0] st, input logic fl,
                       input logic [31:0] np, input logic bf, input logic [31:0] bt);
        rst = r; stall = st; flush = fl; new_pc = np;
        branch_flag_i = bf; branch_target_address_i = bt;
        model_edge();
        @(posedge clk);
        #3;
    endtask

    // Monitor: one expected entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("ce", {31'b0, bus.ce}, {31'b0, e.ce});
                chk("id_pc", bus.id_pc, e.id_pc);
                chk("id_inst", bus.id_inst, e.id_inst);
`ifdef IF_ADDR_EXCP_EN
                chk("id_excepttype", bus.id_excepttype, e.exc);
`endif
            end
        end
    end

    initial begin
        logic [5:0]  st;
        logic [31:0] tgt;
        // Reset and release: pc 0,4,8 with ROM words following one cycle later
        cyc(1, 6'b0, 0, 0, 0, 0);
        cyc(1, 6'b0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 6'b0, 0, 0, 0, 0);
        // Branch while PC/IF stalled for 3 cycles, then taken
        cyc(0, 6'b000011, 0, 0, 1, 32'h100);
        cyc(0, 6'b000011, 0, 0, 0, 0);
        cyc(0, 6'b000011, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        // IF/ID hold under stall 000111, bubble under 000011
        cyc(0, 6'b000111, 0, 0, 0, 0);
        cyc(0, 6'b000111, 0, 0, 0, 0);
        cyc(0, 6'b000011, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        // Flush beats a pending branch, no later jump
        cyc(0, 6'b000011, 0, 0, 1, 32'h100);
        cyc(0, 6'b000011, 1, 32'h20, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 6'b0, 0, 0, 0, 0);
        // Later branch overwrites the pending one
        cyc(0, 6'b000001, 0, 0, 1, 32'h300);
        cyc(0, 6'b000001, 0, 0, 1, 32'h400);
        cyc(0, 6'b0, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        // PC wrap
        cyc(0, 6'b0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        // Misaligned branch target
        cyc(0, 6'b0, 0, 0, 1, 32'h102);
        cyc(0, 6'b0, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0);
        // Reset with a pending branch: no redirect after release
        cyc(0, 6'b000011, 0, 0, 1, 32'h200);
        cyc(1, 6'b000011, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 6'b0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            st = 6'($urandom);
            if ($urandom_range(0, 1) == 0) st[2:0] = 3'b000;
            tgt = $urandom;
            if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
            cyc(($urandom_range(0, 49) == 0), st,
                ($urandom_range(0, 19) == 0), {$urandom} & 32'hFFFF_FFFC,
                ($urandom_range(0, 4) == 0), tgt);
        end
        cyc(0, 6'b0, 0, 0, 0, 0);
        #10;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
- REQ-002 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
- REQ-003 SHALL have rst, input, 1: reset, synchronous and active-high.
- REQ-004 SHALL have stall, input, 6: pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID.
- REQ-005 SHALL have flush, input, 1 and new_pc, input, 32: exception redirect and its target.
- REQ-006 SHALL have branch_flag_i, input, 1 and branch_target_address_i, input, 32: branch redirect from ID.
- REQ-007 SHALL have pc, output, 32 and ce, output, 1: fetch address and chip enable to the instruction ROM.
- REQ-008 SHALL have rom_inst_i, input, 32: instruction returned combinationally by the ROM for pc.
- REQ-009 SHALL have id_pc, output, 32 and id_inst, output, 32: IF/ID register contents to decode.

Function
- REQ-010 SHALL deassert ce while rst=1 and assert ce on the first edge with rst=0.
- REQ-011 SHALL hold pc at RESET_PC while ce=0.
- REQ-012 SHALL apply next-pc priority per edge (ce=1): flush -> new_pc; else stall[0]=1 -> hold pc; else pending or live branch -> target; else pc+4.
- REQ-013 SHALL wrap pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- REQ-014 SHALL latch branch_flag_i and its target into a one-entry pending register when branch_flag_i=1 and stall[0]=1.
- REQ-015 SHALL consume the pending branch on the first edge with stall[0]=0 and clear it on that edge.
- REQ-016 SHALL let a later branch_flag_i overwrite the pending entry.
- REQ-017 SHALL clear the pending entry on flush, with flush winning over any pending or live branch.
- REQ-018 SHALL load id_pc<=pc and id_inst<=rom_inst_i when stall[1]=0.
- REQ-019 SHALL load a bubble (id_pc=0, id_inst=0) when stall[1]=1 and stall[2]=0.
- REQ-020 SHALL hold id_pc and id_inst when stall[1]=1 and stall[2]=1.
- REQ-021 SHALL load a bubble into IF/ID on flush, regardless of stall.
- REQ-022 SHALL feed a bubble into IF/ID when ce=0, since the ROM returns zero.
- REQ-023 SHALL have a latency of one cycle from pc to id_inst.

Reset
- REQ-024 SHALL, on rst=1 at an edge: pc=RESET_PC, ce=0, pending cleared, id_pc=0, id_inst=0.
- REQ-025 SHALL let reset asserted mid-stall or mid-pending-branch discard all in-flight state, with no redirect after release.

Configuration
- REQ-026 SHALL use IF_ADDR_EXCP_EN: when defined, add output id_excepttype, 32.
- REQ-027 SHALL, with IF_ADDR_EXCP_EN defined, set id_excepttype bit 13 when the IF/ID register loads a pc with pc[1:0]!=0.
- REQ-028 SHALL, with IF_ADDR_EXCP_EN defined, load id_inst=0 for such a misaligned pc.
- REQ-029 SHALL, with IF_ADDR_EXCP_EN defined, clear id_excepttype on reset, bubble and flush.
- REQ-030 SHALL, without IF_ADDR_EXCP_EN, omit the port and pass misaligned addresses unchecked.

Structure
- REQ-031 SHALL take InstAddrBus, InstBus, ZeroWord, RstEnable, ChipEnable/ChipDisable, Stop/NoStop and the stall bit indices from the shared defines.v.
- REQ-032 SHALL implement the IF/ID register (REQ-018..022, 027..029) as sub-module if_id.
- REQ-033 SHALL keep the PC and pending-branch logic in if_stage.

Verification
- REQ-034 SHALL cover: reset release with no stall -> ce=1; pc sequence 0x0, 0x4, 0x8; id_inst = ROM word at each pc one cycle later.
- REQ-035 SHALL cover: branch_flag_i=1, target 0x100 while stall=6'b000011 for 3 cycles -> pc held; first unstalled edge pc=0x100; next edge pc=0x104.
- REQ-036 SHALL cover: stall=6'b000011 -> IF/ID bubble (0/0); stall=6'b000111 -> IF/ID holds its prior value.
- REQ-037 SHALL cover: flush=1, new_pc=0x20, branch pending to 0x100 -> pc=0x20, IF/ID bubble, no later jump to 0x100.
- REQ-038 SHALL cover: pc=32'hFFFF_FFFC unstalled -> next pc=0x0.
- REQ-039 SHALL cover, with IF_ADDR_EXCP_EN: branch target 0x102 -> id_excepttype[13]=1 and id_inst=0 one cycle after pc=0x102.
